// File: rtl/queue_dispatch.sv
// Stages up to four instruction bundles and burst-writes them into the dma,
// arithmetic and cache queues in lockstep, so one shared re reads all three.
module queue_dispatch #(
    parameter int IDLE_FLUSH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [21:0] in_dma,
    input  logic        in_arith,
    input  logic [16:0] in_cache,
    input  logic        flush,
    input  logic        dma_full_soon,
    input  logic        arith_full_soon,
    input  logic        cache_full_soon,
    output logic        q_we,
    output logic [1:0]  q_we_count,
    output logic [87:0] dma_dat_w,
    output logic [3:0]  arith_dat_w,
    output logic [67:0] cache_dat_w,
    output logic [2:0]  staged,
    output logic        idle
);

    localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_FLUSH);

    logic [2:0]  count;
    logic [7:0]  idle_cnt;
    logic        flush_pend;
    logic [21:0] dma_slot   [4];
    logic [3:0]  arith_slot;
    logic [16:0] cache_slot [4];
    logic        blocked;
    logic        fire;
    logic        accept;

    // Handshake: a bundle transfers on a posedge where in_valid && in_ready;
    // in_ready is combinational so a full stage still accepts on its write edge.
    always_comb begin
        blocked  = dma_full_soon | arith_full_soon | cache_full_soon;
        fire     = (count != 3'd0) && !blocked &&
                   ((count == 3'd4) || flush_pend || (idle_cnt >= IDLE_LIMIT));
        in_ready = reset && ((count < 3'd4) || fire);
        accept   = in_valid && in_ready;
    end

    assign staged = count;
    assign idle   = (count == 3'd0) && !q_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= 3'd0;
            idle_cnt    <= 8'd0;
            flush_pend  <= 1'b0;
            q_we        <= 1'b0;
            q_we_count  <= 2'd0;
            dma_dat_w   <= '0;
            arith_dat_w <= '0;
            cache_dat_w <= '0;
        end else begin
            q_we <= fire;
            if (fire) begin
                q_we_count <= 2'(count - 3'd1);
                for (int i = 0; i < 4; i++) begin
                    dma_dat_w[22*i +: 22] <= (3'(i) < count) ? dma_slot[i]   : 22'd0;
                    arith_dat_w[i]        <= (3'(i) < count) ? arith_slot[i] : 1'b0;
                    cache_dat_w[17*i +: 17] <= (3'(i) < count) ? cache_slot[i] : 17'd0;
                end
                count <= accept ? 3'd1 : 3'd0;
            end else if (accept) begin
                count <= count + 3'd1;
            end

            if (accept || fire)
                idle_cnt <= 8'd0;
            else if (count == 3'd0)
                idle_cnt <= 8'd0;
            else if (idle_cnt < IDLE_LIMIT)
                idle_cnt <= idle_cnt + 8'd1;

            // A flush arriving with the write edge only sticks for the bundle accepted on it.
            if (fire)
                flush_pend <= flush && accept;
            else if (flush && ((count != 3'd0) || accept))
                flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arith_slot <= '0;
            for (int k = 0; k < 4; k++) begin
                dma_slot[k]   <= '0;
                cache_slot[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && (fire ? (k == 0) : (count == 3'(k)))) begin
                    dma_slot[k]   <= in_dma;
                    arith_slot[k] <= in_arith;
                    cache_slot[k] <= in_cache;
                end
            end
        end
    end

endmodule
